lbuf_readout_timing: RTL and testbench

- Output-side timing generator for the scan converter: the read end of the shared line-buffer interface.
- Free-runs the output raster on the output pixel clock and produces the raster counters, line-buffer read addresses, pixel/line repeat phases and HSYNC/VSYNC/DE that the converter consumes.
- Frame-locks the output raster to the input field so that line-buffer reads trail line-buffer writes.

---
 rtl/lbuf_readout_timing_pkg.sv | 55 +++++
 rtl/lbuf_readout_timing_repeat_ctr.sv | 50 +++++
 rtl/lbuf_readout_timing.sv | 191 +++++++++++++++++++
 tb/tb_lbuf_readout_timing.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lbuf_readout_timing_pkg.sv
// Shared constants for the scan converter line-buffer read/write ends: output timing sets,
// sync polarity and line-buffer depth.
package lbuf_readout_timing_pkg;

  localparam int unsigned CntWidth = 11;

  // Shared with the writer so both ends agree on the ring size.
  localparam int unsigned NUM_LINE_BUFFERS = 40;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  typedef enum logic {
    ModeStd,
    ModeWide
  } out_mode_e;

  typedef struct packed {
    int unsigned h_total;
    int unsigned h_active;
    int unsigned h_synclen;
    int unsigned h_backporch;
    int unsigned v_total;
    int unsigned v_active;
    int unsigned v_synclen;
    int unsigned v_backporch;
    int unsigned h_mult;
    int unsigned v_mult;
  } timing_t;

  localparam timing_t TimingStd = '{
    h_total: 1650, h_active: 1152, h_synclen: 40, h_backporch: 284,
    v_total: 750,  v_active: 672,  v_synclen: 5,  v_backporch: 44,
    h_mult: 3, v_mult: 3
  };

  localparam timing_t TimingWide = '{
    h_total: 1650, h_active: 1280, h_synclen: 40, h_backporch: 220,
    v_total: 750,  v_active: 720,  v_synclen: 5,  v_backporch: 20,
    h_mult: 5, v_mult: 3
  };

  function automatic timing_t mode_timing(out_mode_e mode);
    return (mode == ModeWide) ? TimingWide : TimingStd;
  endfunction

  // Half-open window test: start <= cnt < start + len.
  function automatic logic in_window(logic [CntWidth-1:0] cnt, int unsigned start,
                                     int unsigned len);
    int unsigned c;
    c = {{(32 - CntWidth){1'b0}}, cnt};
    return (c >= start) && (c < start + len);
  endfunction

endpackage

// File: rtl/lbuf_readout_timing_repeat_ctr.sv
// Repeat-phase counter: phase counts 0..mult-1 and each phase wrap advances the line-buffer
// index, which itself wraps at Wrap.
module lbuf_readout_timing_repeat_ctr #(
  parameter int unsigned IdxWidth = 9,
  parameter int unsigned Wrap     = 512
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                restart,
  input  logic                advance,
  input  logic [2:0]          mult,
  output logic [2:0]          phase,
  output logic [IdxWidth-1:0] idx
);

  localparam logic [IdxWidth-1:0] IdxLast = IdxWidth'(Wrap - 1);

  logic [2:0]          phase_q, phase_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic                carry;

  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    carry   = advance && (phase_q == mult - 3'd1);
    if (restart) begin
      phase_d = '0;
      idx_d   = '0;
    end else if (carry) begin
      phase_d = '0;
      idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end else if (advance) begin
      phase_d = phase_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  assign phase = phase_q;
  assign idx   = idx_q;

endmodule

// File: rtl/lbuf_readout_timing.sv
// Output raster generator for the scan converter read side: counters, line-buffer read
// addresses, repeat phases, registered syncs/DE and frame lock to the input field.
module lbuf_readout_timing
  import lbuf_readout_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL     = TimingStd.h_total,
  parameter int unsigned H_ACTIVE    = TimingStd.h_active,
  parameter int unsigned H_SYNCLEN   = TimingStd.h_synclen,
  parameter int unsigned H_BACKPORCH = TimingStd.h_backporch,
  parameter int unsigned V_TOTAL     = TimingStd.v_total,
  parameter int unsigned V_ACTIVE    = TimingStd.v_active,
  parameter int unsigned V_SYNCLEN   = TimingStd.v_synclen,
  parameter int unsigned V_BACKPORCH = TimingStd.v_backporch,
  parameter int unsigned H_MULT      = TimingStd.h_mult,
  parameter int unsigned V_MULT      = TimingStd.v_mult,
  parameter int unsigned LBUF_LINES  = NUM_LINE_BUFFERS,
  parameter int unsigned V_LOCKLINE  = 0
) (
  input  logic        PCLK_in,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        lock_en,
  output logic [10:0] hcnt_ext,
  output logic [10:0] vcnt_ext,
  output logic [8:0]  hcnt_ext_lbuf,
  output logic [5:0]  vcnt_ext_lbuf,
  output logic [2:0]  hctr_ext,
  output logic [2:0]  vctr_ext,
  output logic        HSYNC_ext,
  output logic        VSYNC_ext,
  output logic        DE_ext,
  output logic        locked
);

  localparam int unsigned HStart = H_SYNCLEN + H_BACKPORCH;
  localparam int unsigned VStart = V_SYNCLEN + V_BACKPORCH;

  localparam logic [CntWidth-1:0] HLast    = CntWidth'(H_TOTAL - 1);
  localparam logic [CntWidth-1:0] VLast    = CntWidth'(V_TOTAL - 1);
  localparam logic [CntWidth-1:0] HFirst   = CntWidth'(HStart);
  localparam logic [CntWidth-1:0] VFirst   = CntWidth'(VStart);
  localparam logic [CntWidth-1:0] HSyncEnd = CntWidth'(H_SYNCLEN);
  localparam logic [CntWidth-1:0] VSyncEnd = CntWidth'(V_SYNCLEN);
  localparam logic [CntWidth-1:0] VLock    = CntWidth'(V_LOCKLINE);
  localparam logic [2:0]          HMult    = 3'(H_MULT);
  localparam logic [2:0]          VMult    = 3'(V_MULT);

  localparam bit ParamsOk = (H_MULT >= 1) && (H_MULT <= 5) && (V_MULT >= 1) && (V_MULT <= 5) &&
                            (H_ACTIVE % H_MULT == 0) && (H_ACTIVE / H_MULT <= 511) &&
                            (LBUF_LINES >= 1) && (LBUF_LINES <= 64);

  logic [CntWidth-1:0] hcnt_q, hcnt_d;
  logic [CntWidth-1:0] vcnt_q, vcnt_d;
  logic [CntWidth-1:0] vcnt_inc;
  logic [7:0]          miss_q, miss_d;
  logic                pend_q, pend_d;
  logic                seen_q, seen_d;
  logic                locked_q, locked_d;
  logic                hsync_q, vsync_q, de_q;

  logic h_wrap, frame_wrap, fs_lock, apply, aligned, lost;
  logic h_act_q, v_act_q, h_act_d, v_act_d;
  logic h_restart, h_advance, v_restart, v_advance;

  always_ff @(posedge PCLK_in) begin
    assert (ParamsOk) else $error("lbuf_readout_timing: illegal H_MULT/H_ACTIVE/LBUF_LINES");
  end

  // Raster counters; a lock event only redirects vcnt, so every line keeps full length.
  always_comb begin
    h_wrap     = (hcnt_q == HLast);
    frame_wrap = h_wrap && (vcnt_q == VLast);
    vcnt_inc   = (vcnt_q == VLast) ? '0 : vcnt_q + 11'd1;
    fs_lock    = frame_start && lock_en;
    apply      = h_wrap && (pend_q || fs_lock);
    aligned    = (vcnt_inc == VLock);
    hcnt_d     = h_wrap ? '0 : hcnt_q + 11'd1;
    vcnt_d     = vcnt_q;
    if (h_wrap) begin
      vcnt_d = apply ? VLock : vcnt_inc;
    end
  end

  always_comb begin
    h_act_q   = in_window(hcnt_q, HStart, H_ACTIVE);
    v_act_q   = in_window(vcnt_q, VStart, V_ACTIVE);
    h_act_d   = in_window(hcnt_d, HStart, H_ACTIVE);
    v_act_d   = in_window(vcnt_d, VStart, V_ACTIVE);
    h_restart = !h_act_d || (hcnt_d == HFirst);
    h_advance = h_act_d;
    v_restart = h_wrap && (vcnt_d == VFirst);
    v_advance = h_wrap && v_act_d;
  end

  // Miss counter counts frame wraps since the last frame_start; a wrap on the same cycle as
  // frame_start still counts so the timeout is measured from the pulse itself.
  always_comb begin
    pend_d   = pend_q;
    seen_d   = seen_q;
    locked_d = locked_q;
    miss_d   = miss_q;
    lost     = frame_wrap && !frame_start && (miss_q >= 8'd2);

    if (frame_start) begin
      miss_d = frame_wrap ? 8'd1 : 8'd0;
    end else if (frame_wrap) begin
      miss_d = miss_q + 8'd1;
    end

    if (!lock_en) begin
      pend_d   = 1'b0;
      seen_d   = 1'b0;
      locked_d = 1'b0;
    end else if (apply) begin
      pend_d = 1'b0;
      if (aligned) begin
        seen_d   = 1'b1;
        locked_d = locked_q || seen_q;
      end else begin
        seen_d   = 1'b0;
        locked_d = 1'b0;
      end
    end else if (fs_lock) begin
      pend_d = 1'b1;
    end

    if (lost) begin
      seen_d   = 1'b0;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      miss_q   <= '0;
      pend_q   <= 1'b0;
      seen_q   <= 1'b0;
      locked_q <= 1'b0;
      hsync_q  <= HI;
      vsync_q  <= HI;
      de_q     <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      miss_q   <= miss_d;
      pend_q   <= pend_d;
      seen_q   <= seen_d;
      locked_q <= locked_d;
      // Stage 1: describes the counter values of the previous cycle.
      hsync_q  <= (hcnt_q < HSyncEnd) ? LO : HI;
      vsync_q  <= (vcnt_q < VSyncEnd) ? LO : HI;
      de_q     <= h_act_q && v_act_q;
    end
  end

  lbuf_readout_timing_repeat_ctr #(
    .IdxWidth (9),
    .Wrap     (512)
  ) u_h_rep (
    .clk     (PCLK_in),
    .reset_n (reset_n),
    .restart (h_restart),
    .advance (h_advance),
    .mult    (HMult),
    .phase   (hctr_ext),
    .idx     (hcnt_ext_lbuf)
  );

  lbuf_readout_timing_repeat_ctr #(
    .IdxWidth (6),
    .Wrap     (LBUF_LINES)
  ) u_v_rep (
    .clk     (PCLK_in),
    .reset_n (reset_n),
    .restart (v_restart),
    .advance (v_advance),
    .mult    (VMult),
    .phase   (vctr_ext),
    .idx     (vcnt_ext_lbuf)
  );

  assign hcnt_ext  = hcnt_q;
  assign vcnt_ext  = vcnt_q;
  assign HSYNC_ext = hsync_q;
  assign VSYNC_ext = vsync_q;
  assign DE_ext    = de_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_lbuf_readout_timing.sv
// Directed bench for lbuf_readout_timing on a reduced raster (40 x 30, 3x3 repeat, 4 lines).
module tb_lbuf_readout_timing;

  localparam int HT = 40;
  localparam int VT = 30;
  localparam int FrameClks = HT * VT;

  logic        PCLK_in = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        lock_en;
  logic [10:0] hcnt_ext, vcnt_ext;
  logic [8:0]  hcnt_ext_lbuf;
  logic [5:0]  vcnt_ext_lbuf;
  logic [2:0]  hctr_ext, vctr_ext;
  logic        HSYNC_ext, VSYNC_ext, DE_ext, locked;

  int tests = 0;
  int fails = 0;
  int de_acc = 0;

  always #5 PCLK_in = ~PCLK_in;

  lbuf_readout_timing #(
    .H_TOTAL     (HT),
    .H_ACTIVE    (18),
    .H_SYNCLEN   (4),
    .H_BACKPORCH (6),
    .V_TOTAL     (VT),
    .V_ACTIVE    (18),
    .V_SYNCLEN   (2),
    .V_BACKPORCH (3),
    .H_MULT      (3),
    .V_MULT      (3),
    .LBUF_LINES  (4),
    .V_LOCKLINE  (0)
  ) dut (
    .PCLK_in       (PCLK_in),
    .reset_n       (reset_n),
    .frame_start   (frame_start),
    .lock_en       (lock_en),
    .hcnt_ext      (hcnt_ext),
    .vcnt_ext      (vcnt_ext),
    .hcnt_ext_lbuf (hcnt_ext_lbuf),
    .vcnt_ext_lbuf (vcnt_ext_lbuf),
    .hctr_ext      (hctr_ext),
    .vctr_ext      (vctr_ext),
    .HSYNC_ext     (HSYNC_ext),
    .VSYNC_ext     (VSYNC_ext),
    .DE_ext        (DE_ext),
    .locked        (locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge PCLK_in);
      #1;
      if (DE_ext) de_acc++;
    end
  endtask

  task automatic wait_pos(input int h, input int v, input string tag);
    int   n;
    logic reached;
    n = 0;
    while (!(int'(hcnt_ext) == h && int'(vcnt_ext) == v) && n < 3000) begin
      step(1);
      n++;
    end
    reached = (n < 3000);
    check({tag, "_reach"}, 32'(reached), 32'd1);
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  initial begin
    int de_cnt, hs_cnt, vs_cnt, lb_max, lines_read;

    reset_n     = 1'b0;
    frame_start = 1'b0;
    lock_en     = 1'b0;
    repeat (3) @(posedge PCLK_in);
    #1;
    check("rst_hcnt", 32'(hcnt_ext), 0);
    check("rst_vcnt", 32'(vcnt_ext), 0);
    check("rst_hsync", 32'(HSYNC_ext), 1);
    check("rst_vsync", 32'(VSYNC_ext), 1);
    check("rst_de", 32'(DE_ext), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_hctr", 32'(hctr_ext), 0);
    check("rst_vlbuf", 32'(vcnt_ext_lbuf), 0);

    // Syncs lag the counters by one cycle.
    reset_n = 1'b1;
    step(1);
    check("rel_hcnt", 32'(hcnt_ext), 1);
    check("hsync_lo_first", 32'(HSYNC_ext), 0);
    check("vsync_lo", 32'(VSYNC_ext), 0);
    step(3);
    check("hsync_lo_last", 32'(HSYNC_ext), 0);
    step(1);
    check("hsync_hi", 32'(HSYNC_ext), 1);

    wait_pos(11, 4, "pre_vact");
    check("de_before_vact", 32'(DE_ext), 0);

    // First active line: hcnt 10..27 active.
    wait_pos(10, 5, "hstart");
    check("de_at_hstart", 32'(DE_ext), 0);
    check("hctr_h10", 32'(hctr_ext), 0);
    check("hlbuf_h10", 32'(hcnt_ext_lbuf), 0);
    check("vlbuf_v5", 32'(vcnt_ext_lbuf), 0);
    check("vctr_v5", 32'(vctr_ext), 0);
    step(1);
    check("de_first", 32'(DE_ext), 1);
    check("hctr_h11", 32'(hctr_ext), 1);
    step(1);
    check("hctr_h12", 32'(hctr_ext), 2);
    step(1);
    check("hctr_h13", 32'(hctr_ext), 0);
    check("hlbuf_h13", 32'(hcnt_ext_lbuf), 1);
    wait_pos(27, 5, "hlast");
    check("hlbuf_h27", 32'(hcnt_ext_lbuf), 5);
    check("hctr_h27", 32'(hctr_ext), 2);
    step(1);
    check("de_last", 32'(DE_ext), 1);
    check("hctr_idle", 32'(hctr_ext), 0);
    check("hlbuf_idle", 32'(hcnt_ext_lbuf), 0);
    step(1);
    check("de_off", 32'(DE_ext), 0);

    wait_pos(10, 7, "v7");
    check("vlbuf_v7", 32'(vcnt_ext_lbuf), 0);
    check("vctr_v7", 32'(vctr_ext), 2);
    wait_pos(10, 8, "v8");
    check("vlbuf_v8", 32'(vcnt_ext_lbuf), 1);
    check("vctr_v8", 32'(vctr_ext), 0);
    wait_pos(10, 14, "v14");
    check("vlbuf_v14", 32'(vcnt_ext_lbuf), 3);
    wait_pos(10, 17, "v17");
    check("vlbuf_wrap", 32'(vcnt_ext_lbuf), 0);
    wait_pos(10, 22, "v22");
    check("vlbuf_v22", 32'(vcnt_ext_lbuf), 1);
    check("vctr_v22", 32'(vctr_ext), 2);

    // One full free-running frame.
    wait_pos(0, 0, "frame_origin");
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; lb_max = 0; lines_read = 0;
    for (int i = 0; i < FrameClks; i++) begin
      if (DE_ext) de_cnt++;
      if (!HSYNC_ext) hs_cnt++;
      if (!VSYNC_ext) vs_cnt++;
      if (int'(vcnt_ext_lbuf) > lb_max) lb_max = int'(vcnt_ext_lbuf);
      if (hcnt_ext == 11'd0 && vcnt_ext >= 11'd5 && vcnt_ext < 11'd23 && vctr_ext == 3'd0)
        lines_read++;
      step(1);
    end
    check("frame_de_cnt", 32'(de_cnt), 324);
    check("frame_hs_cnt", 32'(hs_cnt), 120);
    check("frame_vs_cnt", 32'(vs_cnt), 80);
    check("frame_lb_max", 32'(lb_max), 3);
    check("frame_lines", 32'(lines_read), 6);
    check("frame_hcnt", 32'(hcnt_ext), 0);
    check("frame_vcnt", 32'(vcnt_ext), 0);
    wait_pos(0, 5, "v5_again");
    check("vlbuf_restart", 32'(vcnt_ext_lbuf), 0);
    check("vctr_restart", 32'(vctr_ext), 0);

    // Frame lock: corrective jump, then two aligned events.
    lock_en = 1'b1;
    wait_pos(5, 12, "lock1");
    pulse();
    step(HT - 6);
    check("lock1_hcnt", 32'(hcnt_ext), 0);
    check("lock1_vcnt", 32'(vcnt_ext), 0);
    check("lock1_locked", 32'(locked), 0);
    wait_pos(5, VT - 1, "lock2");
    pulse();
    step(HT - 6);
    check("lock2_vcnt", 32'(vcnt_ext), 0);
    check("lock2_locked", 32'(locked), 0);
    // Pulse on the wrap cycle itself.
    wait_pos(HT - 1, VT - 1, "lock3");
    pulse();
    check("lock3_vcnt", 32'(vcnt_ext), 0);
    check("lock3_locked", 32'(locked), 1);

    // Loss of frame_start: locked drops after 2 frames.
    step(FrameClks);
    check("miss1_locked", 32'(locked), 1);
    step(FrameClks - 1);
    check("miss2_pre_locked", 32'(locked), 1);
    step(1);
    check("miss2_locked", 32'(locked), 0);
    check("miss2_hcnt", 32'(hcnt_ext), 0);
    check("miss2_vcnt", 32'(vcnt_ext), 0);

    wait_pos(HT - 1, 10, "wrap_pulse");
    pulse();
    check("wrap_pulse_vcnt", 32'(vcnt_ext), 0);

    // Two pulses in one line produce a single jump.
    wait_pos(5, 20, "dbl_a");
    pulse();
    wait_pos(15, 20, "dbl_b");
    pulse();
    step(HT - 16);
    check("dbl_vcnt", 32'(vcnt_ext), 0);
    step(HT);
    check("dbl_next", 32'(vcnt_ext), 1);

    lock_en = 1'b0;
    wait_pos(5, 12, "free");
    pulse();
    step(HT - 6);
    check("free_vcnt", 32'(vcnt_ext), 13);

    // Async reset mid-active-line.
    wait_pos(15, 8, "rst_mid");
    check("rst_mid_de_pre", 32'(DE_ext), 1);
    reset_n = 1'b0;
    #1;
    check("rstm_hcnt", 32'(hcnt_ext), 0);
    check("rstm_vcnt", 32'(vcnt_ext), 0);
    check("rstm_de", 32'(DE_ext), 0);
    check("rstm_hsync", 32'(HSYNC_ext), 1);
    check("rstm_hctr", 32'(hctr_ext), 0);
    check("rstm_hlbuf", 32'(hcnt_ext_lbuf), 0);
    check("rstm_vlbuf", 32'(vcnt_ext_lbuf), 0);
    @(posedge PCLK_in);
    @(posedge PCLK_in);
    #1;
    reset_n = 1'b1;
    de_acc  = 0;
    wait_pos(10, 5, "rstm_resume");
    check("rstm_no_de", 32'(de_acc), 0);
    step(1);
    check("rstm_de_back", 32'(DE_ext), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
